tuner_sequencer: RTL and testbench

Top-level controller for the tuner datapath. Sequences one measurement cycle: audio frame capture, then max-frequency detection, then a display hold. Arbitrates the displayed note between the frequency detector (tune mode) and the PS/2 mouse selection (play mode). Sits between the mic/spectrum front-end, the max-frequency detector and the VGA/mouse display block, replacing the free-running hold counter at top level.

---
 rtl/tuner_pkg.sv | 16 +
 rtl/tuner_sequencer_if.sv | 30 +++
 rtl/tuner_cycle_timer.sv | 26 ++
 rtl/tuner_sequencer.sv | 171 +++++++++++++++++
 tb/tb_tuner_sequencer.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tuner_pkg.sv
// rtl/tuner_pkg.sv - shared types and widths for the tuner sequencer
package tuner_pkg;

  localparam int NOTE_W  = 6;
  localparam int PITCH_W = 2;
  localparam logic [PITCH_W-1:0] PITCH_NEUTRAL = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_DETECT,
    S_HOLD,
    S_PLAY
  } tuner_state_t;

endpackage

// File: rtl/tuner_sequencer_if.sv
// rtl/tuner_sequencer_if.sv - handshake and display signals between the sequencer and its datapath
interface tuner_sequencer_if;
  import tuner_pkg::*;

  logic               enable;
  logic               play_mode;
  logic               cap_start;
  logic               cap_done;
  logic               det_start;
  logic               det_done;
  logic [NOTE_W-1:0]  det_note;
  logic [PITCH_W-1:0] det_pitch;
  logic [NOTE_W-1:0]  mouse_note;
  logic [NOTE_W-1:0]  disp_note;
  logic [PITCH_W-1:0] disp_pitch;
  logic               disp_valid;
  logic               busy;
  logic               timeout_err;

  modport master (
    input  enable, play_mode, cap_done, det_done, det_note, det_pitch, mouse_note,
    output cap_start, det_start, disp_note, disp_pitch, disp_valid, busy, timeout_err
  );

  modport slave (
    output enable, play_mode, cap_done, det_done, det_note, det_pitch, mouse_note,
    input  cap_start, det_start, disp_note, disp_pitch, disp_valid, busy, timeout_err
  );

endinterface

// File: rtl/tuner_cycle_timer.sv
// rtl/tuner_cycle_timer.sv - loadable down-counter with zero flag, shared by timeout and hold
module tuner_cycle_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/tuner_sequencer.sv
// rtl/tuner_sequencer.sv - capture/detect/hold measurement sequencer with tune/play display arbitration
// Optional detection stability filter: TUNER_STABLE_FILTER_EN
module tuner_sequencer
  import tuner_pkg::*;
#(
  parameter int HOLD_CYCLES    = 8333334,
  parameter int TIMEOUT_CYCLES = 16777215,
  parameter int CNT_W          = 24,
  parameter int STABLE_COUNT   = 3
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  tuner_sequencer_if.master  bus
);

  localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  if (HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1 || STABLE_COUNT < 1 || STABLE_COUNT > 255 ||
      longint'(HOLD_CYCLES - 1) >= (longint'(1) << CNT_W) ||
      longint'(TIMEOUT_CYCLES - 1) >= (longint'(1) << CNT_W)) begin : g_param_check
    $error("tuner_sequencer: parameter out of range");
  end

  tuner_state_t       state_q;
  logic               cap_start_q, det_start_q, disp_valid_q, busy_q, timeout_err_q;
  logic [NOTE_W-1:0]  disp_note_q;
  logic [PITCH_W-1:0] disp_pitch_q;

  logic               tmr_load, tmr_zero;
  logic [CNT_W-1:0]   tmr_load_val;
  logic               det_accept, take_det;

  // play_mode overrides any pending handshake, so a done pulse only counts without it
  assign det_accept = (state_q == S_DETECT) && !bus.play_mode && bus.det_done;

  always_comb begin
    tmr_load     = 1'b0;
    tmr_load_val = TIMEOUT_LOAD;
    case (state_q)
      S_IDLE:    tmr_load = !bus.play_mode && bus.enable;
      S_CAPTURE: tmr_load = !bus.play_mode && bus.cap_done;
      S_DETECT: begin
        tmr_load     = det_accept;
        tmr_load_val = HOLD_LOAD;
      end
      default: ;
    endcase
  end

  tuner_cycle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i      (CLOCK_50),
    .rst_i      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .zero_o     (tmr_zero)
  );

`ifdef TUNER_STABLE_FILTER_EN
  logic [NOTE_W-1:0] prev_note_q;
  logic              prev_valid_q;
  logic [7:0]        match_q, match_d;

  always_comb begin
    if (prev_valid_q && (bus.det_note == prev_note_q)) begin
      match_d = (match_q >= 8'(STABLE_COUNT)) ? match_q : match_q + 8'd1;
    end else begin
      match_d = 8'd1;
    end
    take_det = (match_d == 8'(STABLE_COUNT));
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      prev_note_q  <= '0;
      prev_valid_q <= 1'b0;
      match_q      <= '0;
    end else if (det_accept) begin
      prev_note_q  <= bus.det_note;
      prev_valid_q <= 1'b1;
      match_q      <= match_d;
    end
  end
`else
  assign take_det = 1'b1;
`endif

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cap_start_q   <= 1'b0;
      det_start_q   <= 1'b0;
      disp_note_q   <= '0;
      disp_pitch_q  <= PITCH_NEUTRAL;
      disp_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      cap_start_q <= 1'b0;
      det_start_q <= 1'b0;
      busy_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.play_mode) begin
            state_q <= S_PLAY;
          end else if (bus.enable) begin
            state_q     <= S_CAPTURE;
            cap_start_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        S_CAPTURE: begin
          if (bus.play_mode) begin
            state_q <= S_PLAY;
          end else if (bus.cap_done) begin
            state_q     <= S_DETECT;
            det_start_q <= 1'b1;
            busy_q      <= 1'b1;
          end else if (tmr_zero) begin
            state_q       <= S_IDLE;
            timeout_err_q <= 1'b1;
          end else begin
            busy_q <= 1'b1;
          end
        end
        S_DETECT: begin
          if (bus.play_mode) begin
            state_q <= S_PLAY;
          end else if (bus.det_done) begin
            state_q <= S_HOLD;
            if (take_det) begin
              disp_note_q  <= bus.det_note;
              disp_pitch_q <= bus.det_pitch;
              disp_valid_q <= 1'b1;
            end
          end else if (tmr_zero) begin
            state_q       <= S_IDLE;
            timeout_err_q <= 1'b1;
          end else begin
            busy_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (bus.play_mode) begin
            state_q <= S_PLAY;
          end else if (tmr_zero) begin
            state_q <= S_IDLE;
          end
        end
        S_PLAY: begin
          disp_note_q  <= bus.mouse_note;
          disp_pitch_q <= PITCH_NEUTRAL;
          disp_valid_q <= 1'b1;
          if (!bus.play_mode) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cap_start   = cap_start_q;
  assign bus.det_start   = det_start_q;
  assign bus.disp_note   = disp_note_q;
  assign bus.disp_pitch  = disp_pitch_q;
  assign bus.disp_valid  = disp_valid_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_tuner_sequencer.sv
// tb/tb_tuner_sequencer.sv - self-checking bench for tuner_sequencer
module tb_tuner_sequencer;
  import tuner_pkg::*;

  localparam int HOLD   = 16;
  localparam int TMO    = 32;
  localparam int STABLE = 3;
`ifdef TUNER_STABLE_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tuner_sequencer_if bus();

  tuner_sequencer #(
    .HOLD_CYCLES    (HOLD),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (24),
    .STABLE_COUNT   (STABLE)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  typedef struct {
    logic       en, play, cdone, ddone;
    logic [5:0] dnote;
    logic [1:0] dpitch;
    logic [5:0] mnote;
    logic       cs, ds;
    logic [5:0] note;
    logic [1:0] pitch;
    logic       valid, busy, err;
  } vec_t;

  vec_t vecs[13];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.enable     = 1'b0;
    bus.play_mode  = 1'b0;
    bus.cap_done   = 1'b0;
    bus.det_done   = 1'b0;
    bus.det_note   = '0;
    bus.det_pitch  = '0;
    bus.mouse_note = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input logic cs, input logic ds, input logic [5:0] note,
                               input logic [1:0] pitch, input logic valid, input logic busy, input logic err);
    check({tag, " cap_start"},   32'(bus.cap_start),   32'(cs));
    check({tag, " det_start"},   32'(bus.det_start),   32'(ds));
    check({tag, " disp_note"},   32'(bus.disp_note),   32'(note));
    check({tag, " disp_pitch"},  32'(bus.disp_pitch),  32'(pitch));
    check({tag, " disp_valid"},  32'(bus.disp_valid),  32'(valid));
    check({tag, " busy"},        32'(bus.busy),        32'(busy));
    check({tag, " timeout_err"}, 32'(bus.timeout_err), 32'(err));
  endtask

  task automatic wait_cap_start(input string tag, input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.cap_start && n < limit);
    check({tag, " cap_start seen"}, 32'(bus.cap_start), 32'd1);
  endtask

  task automatic do_detect(input logic [5:0] note, input logic [1:0] pitch);
    int n;
    bus.enable = 1'b1;
    wait_cap_start("detect", 5, n);
    bus.enable   = 1'b0;
    bus.cap_done = 1'b1;
    step();
    bus.cap_done  = 1'b0;
    bus.det_done  = 1'b1;
    bus.det_note  = note;
    bus.det_pitch = pitch;
    step();
    bus.det_done = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         n;
    logic [5:0] seq_note [5];
    logic [5:0] exp_note;
    logic [1:0] exp_pitch;
    logic       exp_valid;

    //            en play cd dd dnote  dpitch mnote | cs ds note pitch valid busy err
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 2'd0, 6'd0,  1'b0, 1'b0, 6'd0,  2'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 2'd0, 6'd0,  1'b1, 1'b0, 6'd0,  2'd0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 2'd0, 6'd0,  1'b0, 1'b1, 6'd0,  2'd0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 6'd5, 2'd2, 6'd0,  1'b0, 1'b0, FILT ? 6'd0 : 6'd5,
                 FILT ? 2'd0 : 2'd2, !FILT, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 2'd0, 6'd0,  1'b0, 1'b0, FILT ? 6'd0 : 6'd5,
                 FILT ? 2'd0 : 2'd2, !FILT, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 2'd0, 6'd9,  1'b0, 1'b0, FILT ? 6'd0 : 6'd5,
                 FILT ? 2'd0 : 2'd2, !FILT, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 2'd0, 6'd9,  1'b0, 1'b0, 6'd9,  2'd0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 6'd7, 2'd3, 6'd10, 1'b0, 1'b0, 6'd10, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 2'd0, 6'd11, 1'b0, 1'b0, 6'd11, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 2'd0, 6'd0,  1'b1, 1'b0, 6'd11, 2'd0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 2'd0, 6'd12, 1'b0, 1'b0, 6'd11, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 2'd0, 6'd3,  1'b0, 1'b0, 6'd3,  2'd0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'd8, 2'd1, 6'd0,  1'b0, 1'b0, 6'd3,  2'd0, 1'b1, 1'b0, 1'b0};

    do_reset();
    check_outputs("reset", 1'b0, 1'b0, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 13; i++) begin
      bus.enable     = vecs[i].en;
      bus.play_mode  = vecs[i].play;
      bus.cap_done   = vecs[i].cdone;
      bus.det_done   = vecs[i].ddone;
      bus.det_note   = vecs[i].dnote;
      bus.det_pitch  = vecs[i].dpitch;
      bus.mouse_note = vecs[i].mnote;
      step();
      check_outputs($sformatf("vec%0d", i), vecs[i].cs, vecs[i].ds, vecs[i].note,
                    vecs[i].pitch, vecs[i].valid, vecs[i].busy, vecs[i].err);
    end

    // Full measurement cycle with hold spacing
    do_reset();
    bus.enable = 1'b1;
    wait_cap_start("main", 5, n);
    repeat (10) step();
    bus.cap_done = 1'b1;
    step();
    bus.cap_done = 1'b0;
    check("main det_start", 32'(bus.det_start), 32'd1);
    repeat (20) step();
    bus.det_done  = 1'b1;
    bus.det_note  = 6'd21;
    bus.det_pitch = 2'b01;
    step();
    bus.det_done = 1'b0;
    check("main disp_note",  32'(bus.disp_note),  FILT ? 32'd0 : 32'd21);
    check("main disp_pitch", 32'(bus.disp_pitch), FILT ? 32'd0 : 32'd1);
    check("main disp_valid", 32'(bus.disp_valid), FILT ? 32'd0 : 32'd1);
    n = 0;
    while (!bus.cap_start && n < 60) begin
      step();
      n++;
    end
    check("main done-to-cap_start spacing", 32'(n + 1), 32'(HOLD + 2));

    // Capture timeout, sticky error
    do_reset();
    bus.enable = 1'b1;
    wait_cap_start("timeout", 5, n);
    bus.enable = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      step();
      n++;
    end
    check("timeout cycles in capture", 32'(n), 32'(TMO));
    check("timeout err set", 32'(bus.timeout_err), 32'd1);
    check("timeout disp_valid", 32'(bus.disp_valid), 32'd0);
    repeat (5) step();
    check("timeout err sticky idle", 32'(bus.timeout_err), 32'd1);
    bus.enable = 1'b1;
    wait_cap_start("timeout restart", 5, n);
    bus.enable   = 1'b0;
    bus.cap_done = 1'b1;
    step();
    bus.cap_done = 1'b0;
    check("timeout err sticky detect", 32'(bus.timeout_err), 32'd1);

    // cap_done in the expiry cycle wins
    do_reset();
    bus.enable = 1'b1;
    wait_cap_start("expiry", 5, n);
    bus.enable = 1'b0;
    repeat (TMO - 1) step();
    bus.cap_done = 1'b1;
    step();
    bus.cap_done = 1'b0;
    check("expiry det_start", 32'(bus.det_start), 32'd1);
    check("expiry busy", 32'(bus.busy), 32'd1);
    check("expiry err", 32'(bus.timeout_err), 32'd0);
    step();
    check("expiry still detect", 32'(bus.busy), 32'd1);

    // play_mode aborts detection, late det_done ignored
    do_reset();
    bus.enable = 1'b1;
    wait_cap_start("play", 5, n);
    bus.enable   = 1'b0;
    bus.cap_done = 1'b1;
    step();
    bus.cap_done = 1'b0;
    step();
    bus.play_mode  = 1'b1;
    bus.mouse_note = 6'd40;
    step();
    check("play abort busy", 32'(bus.busy), 32'd0);
    step();
    check("play disp_note", 32'(bus.disp_note), 32'd40);
    bus.det_done  = 1'b1;
    bus.det_note  = 6'd7;
    bus.det_pitch = 2'b11;
    step();
    bus.det_done = 1'b0;
    check("play late det note",  32'(bus.disp_note),  32'd40);
    check("play late det pitch", 32'(bus.disp_pitch), 32'd0);
    check("play disp_valid",     32'(bus.disp_valid), 32'd1);
    bus.play_mode = 1'b0;
    bus.enable    = 1'b1;
    wait_cap_start("play exit", 5, n);
    check("play exit latency", 32'(n), 32'd2);
    bus.enable = 1'b0;

    // Detection sequence (stability filter when enabled)
    do_reset();
    seq_note = '{6'd12, 6'd12, 6'd13, 6'd13, 6'd13};
    for (int i = 0; i < 5; i++) begin
      do_detect(seq_note[i], 2'b10);
      if (FILT) begin
        exp_note  = (i == 4) ? 6'd13 : 6'd0;
        exp_pitch = (i == 4) ? 2'b10 : 2'b00;
        exp_valid = (i == 4);
      end else begin
        exp_note  = seq_note[i];
        exp_pitch = 2'b10;
        exp_valid = 1'b1;
      end
      check($sformatf("seq%0d disp_note", i),  32'(bus.disp_note),  32'(exp_note));
      check($sformatf("seq%0d disp_pitch", i), 32'(bus.disp_pitch), 32'(exp_pitch));
      check($sformatf("seq%0d disp_valid", i), 32'(bus.disp_valid), 32'(exp_valid));
      repeat (HOLD) step();
    end

    // Asynchronous reset mid-hold
    do_reset();
    for (int i = 0; i < STABLE; i++) begin
      do_detect(6'd21, 2'b01);
      if (i < STABLE - 1) repeat (HOLD) step();
    end
    repeat (3) step();
    check("prehold disp_note", 32'(bus.disp_note), 32'd21);
    rst = 1'b1;
    #2;
    check_outputs("async reset", 1'b0, 1'b0, 6'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
